// File: rtl/receiver.sv
`default_nettype none
// ============================================================================
// Module   : receiver
// Brief    : UART 8N1 receive stage with mid-bit sampling and framing check.
// Revision : 1.0
// ============================================================================
module receiver #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       Dvalid,
  output logic       rxbusy,
  output logic       frame_err
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] H    = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;

  assign rxbusy = (state != IDLE);

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      data      <= '0;
      Dvalid    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      Dvalid    <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          // Start bit must still be low at its midpoint, otherwise it was a glitch
          if (cnt != H) begin
            cnt <= cnt + 1'b1;
          end else if (!rx_s) begin
            state  <= DATA;
            cnt    <= '0;
            bitidx <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            shreg[bitidx] <= rx_s;
            cnt           <= '0;
            if (bitidx == 3'd7) begin
              state <= STOP;
            end else begin
              bitidx <= bitidx + 1'b1;
            end
          end
        end
        STOP: begin
          if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (rx_s) begin
              data   <= shreg;
              Dvalid <= 1'b1;
              state  <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end
        end
        BRK: begin
          // A held-low line must go high before another frame can start
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_receiver.sv
`default_nettype none
// Testbench for receiver: directed frames, scoreboard queue and a pulse monitor.
module tb_receiver;

  localparam int CPB = 16;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic       rx;
  logic [7:0] data;
  logic       Dvalid;
  logic       rxbusy;
  logic       frame_err;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;
  exp_t       exp_q[$];

  // Bench-side transmitter model for the loopback case
  logic [9:0] tx_sh = 10'h3FF;
  int         tx_bits = 0;
  int         tx_cnt = 0;
  logic       tx_line = 1'b1;
  logic       tx_dv = 1'b0;
  logic [7:0] tx_d = 8'h00;

  assign rx = loop_en ? tx_line : rx_drv;

  receiver #(.CLKS_PER_BIT(CPB)) dut (
    .rx_clk   (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .Dvalid   (Dvalid),
    .rxbusy   (rxbusy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (tx_bits == 0) begin
      tx_line <= 1'b1;
      if (tx_dv) begin
        tx_sh   <= {1'b1, tx_d, 1'b0};
        tx_bits <= 10;
        tx_cnt  <= 0;
      end
    end else begin
      tx_line <= tx_sh[0];
      if (tx_cnt == CPB - 1) begin
        tx_cnt  <= 0;
        tx_sh   <= tx_sh >> 1;
        tx_bits <= tx_bits - 1;
      end else begin
        tx_cnt <= tx_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse is matched against the head of the queue
  always @(negedge clk) begin
    exp_t e;
    if (Dvalid || frame_err) begin
      check("dvalid_ferr_exclusive", {31'd0, Dvalid & frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: Dvalid=%0b frame_err=%0b data=%0h expected no pulse (cycle %0d)",
                 Dvalid, frame_err, data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, e.err});
        check("pulse_data", {24'd0, data}, {24'd0, e.data});
        if (e.cyc >= 0) check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit chk_busy);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    exp_q.push_back('{err: !stop, data: (stop ? b : last_good), cyc: cyc + 3 + 7 + 9 * CPB + 1});
    if (stop) last_good = b;
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (chk_busy && i == 0 && j == 1) check("busy_before_start", {31'd0, rxbusy}, 32'd0);
        if (chk_busy && i == 0 && j == 2) check("busy_in_start", {31'd0, rxbusy}, 32'd1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int busy_len;
    repeat (3) @(negedge clk);
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_dvalid", {31'd0, Dvalid}, 32'd0);
    check("reset_rxbusy", {31'd0, rxbusy}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single byte with start-of-busy timing check
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("idle_after_55", {31'd0, rxbusy}, 32'd0);

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // Glitch: 5-cycle low pulse
    rx_drv = 1'b0;
    repeat (5) @(negedge clk);
    rx_drv = 1'b1;
    busy_len = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rxbusy) busy_len++;
    end
    check("glitch_busy_le9", {31'd0, (busy_len <= 9)}, 32'd1);
    check("glitch_busy_seen", {31'd0, (busy_len > 0)}, 32'd1);
    check("glitch_idle_after", {31'd0, rxbusy}, 32'd0);
    check("glitch_data_kept", {24'd0, data}, 32'hA3);

    // Framing error, line held low, then recovery
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("break_busy_held", {31'd0, rxbusy}, 32'd1);
    check("break_data_kept", {24'd0, data}, 32'hA3);
    rx_drv = 1'b1;
    repeat (5) @(negedge clk);
    check("break_released", {31'd0, rxbusy}, 32'd0);
    repeat (10) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // Reset in the middle of data bit 4 of 8'hF0
    begin
      logic [9:0] fb;
      fb = {1'b1, 8'hF0, 1'b0};
      for (int i = 0; i < 5; i++) begin
        rx_drv = fb[i];
        repeat (CPB) @(negedge clk);
      end
      rx_drv = fb[5];
      repeat (8) @(negedge clk);
    end
    check("pre_reset_busy", {31'd0, rxbusy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midreset_data", {24'd0, data}, 32'h00);
    check("midreset_rxbusy", {31'd0, rxbusy}, 32'd0);
    check("midreset_dvalid", {31'd0, Dvalid}, 32'd0);
    check("midreset_ferr", {31'd0, frame_err}, 32'd0);
    rx_drv = 1'b1;
    last_good = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("after_reset_idle", {31'd0, rxbusy}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b0);
    repeat (10) @(negedge clk);

    // Loopback through the transmitter model
    loop_en = 1'b1;
    exp_q.push_back('{err: 1'b0, data: 8'h55, cyc: -1});
    tx_d  = 8'h55;
    tx_dv = 1'b1;
    @(negedge clk);
    tx_dv = 1'b0;
    repeat (200) @(negedge clk);
    loop_en = 1'b0;
    repeat (5) @(negedge clk);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/receiver.md
# receiver

UART receive stage: the downstream consumer of the `transmitter` serial line. It recovers 8N1 frames from the asynchronous `tx` wire and presents each received byte with a one-cycle valid strobe. The frame format is idle high, one start bit (0), 8 data bits LSB first, and one stop bit (1). The block oversamples the line at `CLKS_PER_BIT` `rx_clk` cycles per bit, samples at mid-bit, and flags framing errors.

## Interface
- `CLKS_PER_BIT`, default 16: `rx_clk` cycles per serial bit; legal range ≥ 4.
- `H`, derived, not overridable: `(CLKS_PER_BIT-1)/2`, integer division; equals 7 at the default.
- `rx_clk`, in, 1: the block's single clock; all logic is on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: serial line, asynchronous to `rx_clk`; idle high.
- `data`, out, 8: last good received byte; holds until the next good frame.
- `Dvalid`, out, 1: one-cycle pulse when `data` has just been updated.
- `rxbusy`, out, 1: high whenever the FSM is not in IDLE.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchronizer**: `rx` passes through 2 flops and appears as `rx_s`; both flops reset to 1. The FSM uses only `rx_s`.
- **Counters**: `cnt` covers 0..`CLKS_PER_BIT-1` and is `$clog2(CLKS_PER_BIT)` bits wide. `bitidx` covers 0..7 and is 3 bits wide.
- **FSM states**: IDLE, START, DATA, STOP, BREAK.
- **IDLE**
  - If `rx_s==0`: go to START with `cnt=0`.
- **START**
  - If `cnt!=H`: `cnt++`.
  - If `cnt==H` and `rx_s==0`: go to DATA with `cnt=0`, `bitidx=0`.
  - If `cnt==H` and `rx_s==1`: glitch, return to IDLE with no output pulse.
- **DATA**
  - If `cnt!=CLKS_PER_BIT-1`: `cnt++`.
  - Else: shift `rx_s` into `shreg[bitidx]` (LSB first) and set `cnt=0`.
    - If `bitidx==7`: go to STOP.
    - Else: `bitidx++`.
- **STOP**
  - If `cnt!=CLKS_PER_BIT-1`: `cnt++`.
  - If `cnt==CLKS_PER_BIT-1` and `rx_s==1`: `data<=shreg`, `Dvalid<=1` for the next cycle, go to IDLE.
  - If `cnt==CLKS_PER_BIT-1` and `rx_s==0`: `frame_err<=1` for the next cycle, `data` unchanged, go to BREAK.
- **BREAK**
  - Wait for `rx_s==1`, then go to IDLE. This prevents a held-low line (break) from retriggering frames.
- **Outputs**
  - `rxbusy = (state!=IDLE)`, decoded combinationally from the state register.
  - `Dvalid`, `frame_err` and `data` are registered.
  - No downstream backpressure: the consumer must capture `data` on the `Dvalid` cycle. A later frame overwrites `data`.

## Timing
- **Reset values**: `data=8'h00`, `Dvalid=0`, `frame_err=0`, `rxbusy=0`, state IDLE, counters 0, synchronizer flops 1.
- **Reset mid-frame**: returns immediately (asynchronously) to IDLE. The partial byte is discarded and no pulse is generated.
- **Latency**: let E0 be the `rx_clk` edge that first samples `rx` low.
  - START entered after E2.
  - Start-bit check at E(3+H).
  - Bit k sampled at E(3+H+(k+1)·CLKS_PER_BIT).
  - Stop sampled at E(3+H+9·CLKS_PER_BIT).
  - `Dvalid`/`frame_err` are high for the one cycle following that edge: after E154 at the default.
- **Glitch rejection**: a low pulse on `rx_s` shorter than H+1 cycles is rejected.
- **Back-to-back frames**: the FSM returns to IDLE at mid-stop-bit. A start edge arriving at the next bit boundary is detected without loss.
- **Exclusivity**: `Dvalid` and `frame_err` are never high in the same cycle.
- **Line low at reset release**: the FSM enters START; the line must be genuinely low through the check to proceed.

## Test plan
- **Single byte**: `CLKS_PER_BIT=16`; drive `8'h55` frame (start 0, LSB first, stop 1) → exactly one `Dvalid` pulse, 154 cycles after E0, `data==8'h55`, `frame_err` never high; `rxbusy` high from E2+1 until `Dvalid`.
- **Back-to-back bytes**: `8'h00`, `8'hFF`, `8'hA3` with no idle gap → three `Dvalid` pulses spaced 160 cycles apart; `data` reads 00, FF, A3 in order.
- **Glitch**: 5-cycle low pulse on `rx` → no `Dvalid`, no `frame_err`; `rxbusy` high ≤ 9 cycles, then low.
- **Framing error**: frame `8'h3C` with stop bit 0, line held low 40 more cycles → `frame_err` pulses once, `data` keeps its previous value, `rxbusy` stays high until the line returns high. A following good `8'h81` frame is then received correctly.
- **Reset mid-frame**: assert `rst` during data bit 4 of `8'hF0` → outputs return to reset values immediately, no pulse. The next full `8'h12` frame yields `data==8'h12`.
- **Transmitter loopback**: `transmitter.tx` drives `rx`, with the transmitter's bit time equal to `CLKS_PER_BIT` cycles of `rx_clk`; send `8'h55` via `Dvalid`/`data` on the TX side → RX `data==8'h55`.
